// File: rtl/meas_pkg.sv
// meas_pkg: shared constants, FSM state encoding and checksum helper
// for the measurement packetizer and its UART byte handshake.
package meas_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         PKT_LEN       = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_ACK,
        ST_DRAIN,
        ST_DONE
    } meas_state_t;

    // SYNC is deliberately left out of the sum.
    function automatic logic [7:0] meas_checksum(input logic [23:0] d);
        return d[7:0] + d[15:8] + d[23:16];
    endfunction

endpackage

// File: rtl/uart_tx_handshake.sv
// uart_tx_handshake: launches one byte at a time on the UART
// tx_start/tx_busy handshake, with a timeout on the busy acknowledge.
module uart_tx_handshake
    import meas_pkg::*;
#(
    parameter int ACK_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_byte_valid,
    input  logic [7:0] i_byte,
    input  logic       i_tx_busy,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_byte_done
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    meas_state_t      r_state;
    meas_state_t      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tx_data;
    logic             w_load;
    logic             w_timeout;
    logic             w_drain_done;

    assign o_tx_start   = (r_state == ST_START) && !i_tx_busy;
    assign w_drain_done = (r_state == ST_DRAIN) && !i_tx_busy;
    assign o_byte_done  = w_drain_done;
    assign w_timeout    = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign o_tx_data    = r_tx_data;

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        unique case (r_state)
            ST_START: if (o_tx_start) w_next = ST_ACK;
            ST_ACK:   if (i_tx_busy || w_timeout) w_next = ST_DRAIN;
            ST_DRAIN: if (w_drain_done) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        // Next byte is taken on DRAIN exit so tx_data never moves mid-byte.
        if (i_byte_valid && (r_state == ST_IDLE || w_drain_done)) begin
            w_load = 1'b1;
            w_next = ST_START;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_tx_data <= '0;
        end else begin
            if (r_state == ST_ACK) r_cnt <= r_cnt + 1'b1;
            else                   r_cnt <= '0;
            if (w_load) r_tx_data <= i_byte;
        end
    end

endmodule

// File: rtl/meas_packetizer.sv
// meas_packetizer: frames 24-bit averaged results as 5-byte UART packets
// (SYNC, LSB, mid, MSB, checksum) with one pending slot and sticky overrun.
module meas_packetizer
    import meas_pkg::*;
#(
    parameter int         DATA_W      = 24,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         ACK_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] result,
    input  logic              result_valid,
    input  logic              overrun_clr,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              pkt_busy,
    output logic              overrun
);

    meas_state_t       r_state;
    meas_state_t       w_next;
    logic [DATA_W-1:0] r_pr;
    logic [DATA_W-1:0] r_pb;
    logic              r_pb_full;
    logic [7:0]        r_chk;
    logic [2:0]        r_idx;
    logic              r_overrun;

    logic              w_hs_valid;
    logic [7:0]        w_hs_byte;
    logic [2:0]        w_sel;
    logic              w_byte_done;
    logic              w_last;
    logic              w_idx_inc;
    logic              w_pr_from_in;
    logic              w_pr_from_pb;
    logic              w_pb_wr;
    logic              w_drop;

    assign w_last   = (r_idx == 3'(PKT_LEN - 1));
    assign pkt_busy = (r_state != ST_IDLE) || r_pb_full;
    assign overrun  = r_overrun;

    // ST_START here spans the whole START/ACK/DRAIN of one byte.
    always_comb begin
        w_next       = r_state;
        w_hs_valid   = 1'b0;
        w_idx_inc    = 1'b0;
        w_pr_from_in = 1'b0;
        w_pr_from_pb = 1'b0;
        w_pb_wr      = 1'b0;
        w_drop       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (result_valid) begin
                    w_pr_from_in = 1'b1;
                    w_next       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!tx_busy) begin
                    w_hs_valid = 1'b1;
                    w_next     = ST_START;
                end
            end
            ST_START: begin
                if (w_byte_done) begin
                    if (w_last) begin
                        w_next = ST_DONE;
                    end else begin
                        w_hs_valid = 1'b1;
                        w_idx_inc  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (r_pb_full) begin
                    w_pr_from_pb = 1'b1;
                    w_pb_wr      = result_valid;
                    w_next       = ST_LOAD;
                end else if (result_valid) begin
                    w_pr_from_in = 1'b1;
                    w_next       = ST_LOAD;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (result_valid && (r_state == ST_LOAD || r_state == ST_START)) begin
            if (r_pb_full) w_drop  = 1'b1;
            else           w_pb_wr = 1'b1;
        end
    end

    always_comb begin
        w_sel     = (r_state == ST_LOAD) ? 3'd0 : r_idx + 3'd1;
        w_hs_byte = r_chk;
        unique case (w_sel)
            3'd0:    w_hs_byte = SYNC_BYTE;
            3'd1:    w_hs_byte = r_pr[7:0];
            3'd2:    w_hs_byte = r_pr[15:8];
            3'd3:    w_hs_byte = r_pr[23:16];
            default: w_hs_byte = r_chk;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pr      <= '0;
            r_pb      <= '0;
            r_pb_full <= 1'b0;
            r_chk     <= '0;
            r_idx     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_pr_from_in) begin
                r_pr  <= result;
                r_chk <= meas_checksum(result);
                r_idx <= '0;
            end else if (w_pr_from_pb) begin
                r_pr  <= r_pb;
                r_chk <= meas_checksum(r_pb);
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_pb_wr) begin
                r_pb      <= result;
                r_pb_full <= 1'b1;
            end else if (w_pr_from_pb) begin
                r_pb_full <= 1'b0;
            end
            if (w_drop)           r_overrun <= 1'b1;
            else if (overrun_clr) r_overrun <= 1'b0;
        end
    end

    uart_tx_handshake #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_hs (
        .clk         (clk),
        .reset       (reset),
        .i_byte_valid(w_hs_valid),
        .i_byte      (w_hs_byte),
        .i_tx_busy   (tx_busy),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .o_byte_done (w_byte_done)
    );

endmodule

// File: tb/tb_meas_packetizer.sv
// tb_meas_packetizer: UART model plus packet-level reference checks
// for meas_packetizer (directed cases and a randomized run).
module tb_meas_packetizer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] result = '0;
    logic        result_valid = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        pkt_busy;
    logic        overrun;

    int          n_cmp = 0;
    int          n_err = 0;
    int          busy_len = 10;
    bit          busy_rand = 1'b0;
    int          bcnt = 0;
    logic [7:0]  cap_q[$];
    time         start_t[$];
    time         last_fall = 0;
    time         t_pulse = 0;
    logic [23:0] exp_q[$];
    logic [23:0] sub_q[$];
    bit          req_q[$];
    int          hs_viol = 0;
    logic        prev_rst = 1'b1;
    logic        prev_busy = 1'b0;
    logic [7:0]  prev_data = '0;

    meas_packetizer dut (
        .clk         (clk),
        .reset       (reset),
        .result      (result),
        .result_valid(result_valid),
        .overrun_clr (overrun_clr),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .pkt_busy    (pkt_busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // UART model: busy for a fixed or random number of cycles per byte.
    always @(posedge clk) begin
        if (tx_start) begin
            int len;
            cap_q.push_back(tx_data);
            start_t.push_back($time);
            len = busy_rand ? int'($urandom_range(0, 12)) : busy_len;
            if (len > 0) begin
                tx_busy <= 1'b1;
                bcnt    <= len;
            end
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) begin
                tx_busy   <= 1'b0;
                last_fall <= $time;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && !prev_rst && tx_busy && prev_busy && tx_data != prev_data)
            hs_viol++;
        if (!reset && tx_start && tx_busy)
            hs_viol++;
        prev_rst  = reset;
        prev_busy = tx_busy;
        prev_data = tx_data;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [23:0] r, input int b);
        int s;
        s = (r & 255) + ((r >> 8) & 255) + ((r >> 16) & 255);
        if (b == 0) return 8'hA5;
        if (b == 4) return 8'(s % 256);
        return 8'((r >> (8 * (b - 1))) & 255);
    endfunction

    task automatic pulse(input logic [23:0] v);
        @(negedge clk);
        result       = v;
        result_valid = 1'b1;
        t_pulse      = $time + 5;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int lim);
        int k;
        k = 0;
        @(negedge clk);
        while ((pkt_busy || tx_busy) && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (k >= lim) check({tag, "_timeout"}, pkt_busy, 0);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, cap_q.size(), 5 * exp_q.size());
        foreach (exp_q[p])
            for (int b = 0; b < 5; b++)
                if (5 * p + b < cap_q.size())
                    check($sformatf("%s_p%0d_b%0d", tag, p, b),
                          cap_q[5*p+b], ref_byte(exp_q[p], b));
    endtask

    task automatic clear_caps();
        cap_q.delete();
        start_t.delete();
        exp_q.delete();
    endtask

    initial begin
        int          k;
        int          si;
        int          drops;
        int          lost;
        int          badreq;
        logic [23:0] pay;
        bit          found;
        time         t_low;

        #1 reset = 1'b1;
        idle_cycles(3);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_pkt_busy", pkt_busy, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        idle_cycles(2);

        // Single result, 10-cycle busy per byte.
        clear_caps();
        exp_q.push_back(24'h123456);
        pulse(24'h123456);
        wait_done("t1", 400);
        t_low = $time;
        check_stream("t1");
        if (start_t.size() > 0)
            check("t1_latency", (start_t[0] - t_pulse) / 10, 2);
        // DRAIN sees busy low, DONE follows, IDLE one cycle later.
        check("t1_pkt_busy_fall", (t_low - 5 - last_fall) / 10, 2);

        // Checksum wrap and all-zero payload.
        clear_caps();
        exp_q.push_back(24'hFFFFFF);
        exp_q.push_back(24'h000000);
        pulse(24'hFFFFFF);
        wait_done("t2a", 400);
        pulse(24'h000000);
        wait_done("t2b", 400);
        check_stream("t2");

        // Back-to-back: second result parks in the pending slot.
        clear_caps();
        exp_q.push_back(24'h000001);
        exp_q.push_back(24'h000002);
        pulse(24'h000001);
        idle_cycles(3);
        pulse(24'h000002);
        wait_done("t3a", 800);
        check_stream("t3a");
        check("t3a_overrun", overrun, 0);

        // Third result during packet 1 is dropped.
        clear_caps();
        exp_q.push_back(24'h000001);
        exp_q.push_back(24'h000002);
        pulse(24'h000001);
        idle_cycles(3);
        pulse(24'h000002);
        idle_cycles(15);
        pulse(24'h000003);
        check("t3b_overrun_set", overrun, 1);
        wait_done("t3b", 800);
        check_stream("t3b");
        check("t3b_overrun_sticky", overrun, 1);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("t3b_overrun_clr", overrun, 0);

        // Busy never rises: every byte waits out the ACK timeout.
        busy_len = 0;
        clear_caps();
        exp_q.push_back(24'h0A0B0C);
        pulse(24'h0A0B0C);
        wait_done("t4", 400);
        check_stream("t4");
        for (int i = 1; i < 5; i++)
            if (i < start_t.size())
                check($sformatf("t4_gap%0d", i),
                      (start_t[i] - start_t[i-1]) / 10, 6);

        // Reset in the middle of byte 2, with overrun already set.
        busy_len = 10;
        clear_caps();
        pulse(24'h111111);
        idle_cycles(2);
        pulse(24'h222222);
        idle_cycles(2);
        pulse(24'h333333);
        check("t5_overrun_pre", overrun, 1);
        k = 0;
        while (cap_q.size() < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t5_byte2_seen", cap_q.size() >= 2, 1);
        idle_cycles(3);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_tx_start", tx_start, 0);
        check("t5_rst_tx_data", tx_data, 0);
        check("t5_rst_pkt_busy", pkt_busy, 0);
        check("t5_rst_overrun", overrun, 0);
        idle_cycles(2);
        reset = 1'b0;
        clear_caps();
        exp_q.push_back(24'hABCDEF);
        pulse(24'hABCDEF);
        wait_done("t5", 400);
        check_stream("t5");

        // Randomized results and busy lengths.
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        busy_rand = 1'b1;
        clear_caps();
        for (int n = 0; n < 30; n++) begin
            idle_cycles($urandom_range(0, 50));
            @(negedge clk);
            req_q.push_back(!pkt_busy);
            result       = 24'($urandom);
            result_valid = 1'b1;
            sub_q.push_back(result);
            @(negedge clk);
            result_valid = 1'b0;
        end
        wait_done("rnd", 4000);
        check("rnd_len_mod5", cap_q.size() % 5, 0);
        check("rnd_some_sent", cap_q.size() >= 5, 1);
        si = 0;
        drops = 0;
        lost = 0;
        badreq = 0;
        for (int p = 0; p + 4 < cap_q.size(); p += 5) begin
            pay = {cap_q[p+3], cap_q[p+2], cap_q[p+1]};
            check("rnd_sync", cap_q[p], 8'hA5);
            check("rnd_chk", cap_q[p+4], ref_byte(pay, 4));
            found = 1'b0;
            while (!found && si < sub_q.size()) begin
                if (sub_q[si] == pay) begin
                    found = 1'b1;
                end else begin
                    drops++;
                    if (req_q[si]) badreq++;
                end
                si++;
            end
            if (!found) lost++;
        end
        while (si < sub_q.size()) begin
            drops++;
            if (req_q[si]) badreq++;
            si++;
        end
        check("rnd_order_lost", lost, 0);
        check("rnd_idle_result_dropped", badreq, 0);
        check("rnd_overrun", overrun, drops > 0);
        check("hs_rules", hs_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, %0d errors so far", n_err);
        $fatal(1);
    end

endmodule
